// File: rtl/vec_seq_pkg.sv
// Shared types and default constants for the vec_seq vector sequencer.
// Optional compare masking is enabled with VEC_SEQ_MASK_EN.
package vec_seq_pkg;

  localparam int AW_DEF     = 12;
  localparam int RW_DEF     = 12;
  localparam int CW_DEF     = 16;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PREP,
    APPLY,
    CHECK,
    DONE
  } state_t;

  // Width of the settle counter; it counts 0 .. SETTLE-1 and is never narrower than 1 bit.
  function automatic int settle_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/vec_seq_if.sv
// ROM and DUT stimulus/response bus between vec_seq and the bit-slice core under test.
// cmp_mask exists only when VEC_SEQ_MASK_EN is defined.
interface vec_seq_if
  import vec_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
);

  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_ref;
  logic [AW-1:0] vec;
  logic          phase;
  logic          dut_ce;
  logic [RW-1:0] dut_res;
`ifdef VEC_SEQ_MASK_EN
  logic [RW-1:0] cmp_mask;
`endif

  modport master (
    output rom_addr,
    output vec,
    output phase,
    output dut_ce,
`ifdef VEC_SEQ_MASK_EN
    input  cmp_mask,
`endif
    input  rom_ref,
    input  dut_res
  );

  modport slave (
    input  rom_addr,
    input  vec,
    input  phase,
    input  dut_ce,
`ifdef VEC_SEQ_MASK_EN
    output cmp_mask,
`endif
    output rom_ref,
    output dut_res
  );

endinterface

// File: rtl/vec_seq_cmp.sv
// Result compare, saturating mismatch counter and first-failure capture for vec_seq.
// With VEC_SEQ_MASK_EN defined the compare and captured xor are qualified by cmp_mask.
module vec_seq_cmp
  import vec_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          chk,
  input  logic [AW-1:0] vec,
  input  logic [RW-1:0] rom_ref,
  input  logic [RW-1:0] dut_res,
`ifdef VEC_SEQ_MASK_EN
  input  logic [RW-1:0] cmp_mask,
`endif
  output logic          mismatch,
  output logic          fail,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [RW-1:0] fail_xor
);

  logic [RW-1:0] diff_p0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Stage p0: combinational difference, consumed by the FSM in CHECK
  always_comb begin
`ifdef VEC_SEQ_MASK_EN
    diff_p0 = (dut_res ^ rom_ref) & cmp_mask;
`else
    diff_p0 = dut_res ^ rom_ref;
`endif
    mismatch = |diff_p0;
  end

  // Stage p1: registered result of the CHECK-cycle compare
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_xor  <= '0;
    end else if (chk && mismatch) begin
      err_cnt <= sat_inc(err_cnt);
      fail    <= 1'b1;
      if (!fail) begin
        fail_addr <= vec;
        fail_xor  <= diff_p0;
      end
    end
  end

endmodule

// File: rtl/vec_seq.sv
// Vector sequencer: fetches reference words, drives preload/operate phases into the DUT
// and self-checks the result. VEC_SEQ_MASK_EN enables the cmp_mask compare qualifier.
module vec_seq
  import vec_seq_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int RW     = RW_DEF,
  parameter int CW     = CW_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  vec_seq_if.master     bus,
  input  logic          start,
  input  logic          stop_on_fail,
  input  logic [AW-1:0] vec_last,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [RW-1:0] fail_xor
);

  localparam int SW = settle_w(SETTLE);

  state_t        state_q, state_d;
  logic [AW-1:0] vec_q;
  logic [AW-1:0] last_q;
  logic          stop_q;
  logic          done_q;
  logic [SW-1:0] settle_q;
  logic          start_acc;
  logic          vec_inc;
  logic          mismatch;

  assign start_acc = start && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      last_q   <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        vec_q  <= '0;
        last_q <= vec_last;
        stop_q <= stop_on_fail;
        done_q <= 1'b0;
      end else if (vec_inc) begin
        vec_q <= vec_q + AW'(1);
      end
      if (state_d == DONE) done_q <= 1'b1;
      settle_q <= (state_q == APPLY) ? settle_q + SW'(1) : '0;
    end
  end

  // Termination is decided before the increment, so a full-depth run never wraps vec.
  always_comb begin
    state_d = state_q;
    vec_inc = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = PREP;
      PREP:  state_d = APPLY;
      APPLY: if (settle_q == SW'(SETTLE - 1)) state_d = CHECK;
      CHECK: begin
        if (mismatch && stop_q) begin
          state_d = DONE;
        end else if (vec_q == last_q) begin
          state_d = DONE;
        end else begin
          vec_inc = 1'b1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_addr = vec_q;
  assign bus.vec      = vec_q;
  assign bus.phase    = (state_q == APPLY) || (state_q == CHECK);
  // A reset cycle must never commit a DUT step, even if it lands in PREP or CHECK.
  assign bus.dut_ce   = !rst && ((state_q == PREP) || (state_q == CHECK));
  assign busy         = (state_q == FETCH) || (state_q == PREP) ||
                        (state_q == APPLY) || (state_q == CHECK);
  assign done         = done_q;

  vec_seq_cmp #(
    .AW(AW),
    .RW(RW),
    .CW(CW)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .chk      (state_q == CHECK),
    .vec      (vec_q),
    .rom_ref  (bus.rom_ref),
    .dut_res  (bus.dut_res),
`ifdef VEC_SEQ_MASK_EN
    .cmp_mask (bus.cmp_mask),
`endif
    .mismatch (mismatch),
    .fail     (fail),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .fail_xor (fail_xor)
  );

endmodule

// File: tb/tb_vec_seq.sv
// Scoreboard bench for vec_seq: synchronous ROM, identity DUT with injectable faults,
// a CW=16/SETTLE=1 unit and a CW=2/SETTLE=2 unit. Mask cases need VEC_SEQ_MASK_EN.
module tb_vec_seq;
  import vec_seq_pkg::*;

  localparam int AW = 4;
  localparam int RW = 12;

  typedef struct {
    int busy;
    int ce;
    int err;
    int faddr;
    int fxor;
    int vec;
    int fail;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [AW-1:0] last0 = '0, last1 = '0;
  logic          busy0, done0, fail0, busy1, done1, fail1;
  logic [15:0]   err0;
  logic [1:0]    err1;
  logic [AW-1:0] faddr0, faddr1;
  logic [RW-1:0] fxor0, fxor1;

  logic [15:0]   fv0 = '0;
  logic [RW-1:0] fm0 = '0, fm1 = '0;
  logic [RW-1:0] rom [16];

  int   n_vec = 0;
  int   n_mis = 0;
  exp_t exp0_q[$];
  exp_t exp1_q[$];
  int   vq0[$];

  vec_seq_if #(.AW(AW), .RW(RW)) if0 ();
  vec_seq_if #(.AW(AW), .RW(RW)) if1 ();

  always @(posedge clk) begin
    if0.rom_ref <= rom[if0.rom_addr];
    if1.rom_ref <= rom[if1.rom_addr];
  end

  assign if0.dut_res = if0.rom_ref ^ (fv0[if0.vec] ? fm0 : '0);
  assign if1.dut_res = if1.rom_ref ^ fm1;

`ifdef VEC_SEQ_MASK_EN
  logic [RW-1:0] cmask = '1;
  assign if0.cmp_mask = cmask;
  assign if1.cmp_mask = '1;
`endif

  vec_seq #(.AW(AW), .RW(RW), .CW(16), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .start(start0), .stop_on_fail(stop0),
    .vec_last(last0), .busy(busy0), .done(done0), .fail(fail0), .err_cnt(err0),
    .fail_addr(faddr0), .fail_xor(fxor0)
  );

  vec_seq #(.AW(AW), .RW(RW), .CW(2), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .start(start1), .stop_on_fail(stop1),
    .vec_last(last1), .busy(busy1), .done(done1), .fail(fail1), .err_cnt(err1),
    .fail_addr(faddr1), .fail_xor(fxor1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one run: which vectors are checked and what the sticky state ends at.
  function automatic exp_t model(input int last, input bit stop, input logic [15:0] fv,
                                 input logic [RW-1:0] eff, input int settle, input int cw);
    exp_t e;
    int   n;
    e = '{default: 0};
    n = 0;
    for (int v = 0; v <= last; v++) begin
      n++;
      e.vec = v;
      if (fv[v] && eff != 0) begin
        if (e.fail == 0) begin
          e.faddr = v;
          e.fxor  = int'(eff);
        end
        e.fail = 1;
        if (e.err < (1 << cw) - 1) e.err++;
        if (stop) break;
      end
    end
    e.busy = n * (settle + 3);
    e.ce   = 2 * n;
    return e;
  endfunction

  int   bcyc0 = 0, ce0 = 0, bcyc1 = 0, ce1 = 0;
  logic busy0_d = 1'b0, done0_d = 1'b0, busy1_d = 1'b0, done1_d = 1'b0;

  always @(negedge clk) begin : mon0
    exp_t e;
    int   v;
    if (busy0 && !busy0_d) begin
      bcyc0 = 0;
      ce0   = 0;
    end
    if (busy0) bcyc0++;
    if (if0.dut_ce) ce0++;
    if (if0.dut_ce && if0.phase) begin
      if (vq0.size() == 0) chk("check_unexpected", 32'(vq0.size()), 1);
      else begin
        v = vq0.pop_front();
        chk("check_vec", 32'(if0.vec), v);
      end
    end
    if (done0 && !done0_d) begin
      if (exp0_q.size() == 0) chk("done0_unexpected", 32'(exp0_q.size()), 1);
      else begin
        e = exp0_q.pop_front();
        chk("busy_cycles", bcyc0, e.busy);
        chk("dut_ce_pulses", ce0, e.ce);
        chk("err_cnt", err0, e.err);
        chk("fail", fail0, e.fail);
        chk("fail_addr", faddr0, e.faddr);
        chk("fail_xor", fxor0, e.fxor);
        chk("final_vec", if0.vec, e.vec);
        chk("busy_at_done", busy0, 0);
      end
    end
    busy0_d = busy0;
    done0_d = done0;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (busy1 && !busy1_d) begin
      bcyc1 = 0;
      ce1   = 0;
    end
    if (busy1) bcyc1++;
    if (if1.dut_ce) ce1++;
    if (done1 && !done1_d) begin
      if (exp1_q.size() == 0) chk("done1_unexpected", 32'(exp1_q.size()), 1);
      else begin
        e = exp1_q.pop_front();
        chk("u1_busy_cycles", bcyc1, e.busy);
        chk("u1_dut_ce_pulses", ce1, e.ce);
        chk("u1_err_cnt_sat", err1, e.err);
        chk("u1_fail", fail1, e.fail);
        chk("u1_fail_addr", faddr1, e.faddr);
        chk("u1_fail_xor", fxor1, e.fxor);
      end
    end
    busy1_d = busy1;
    done1_d = done1;
  end

  task automatic run0(input int last, input bit stop, input logic [15:0] fv,
                      input logic [RW-1:0] fm, input logic [RW-1:0] cm);
    exp_t e;
    e = model(last, stop, fv, fm & cm, 1, 16);
    exp0_q.push_back(e);
    for (int v = 0; v <= e.vec; v++) vq0.push_back(v);
    @(posedge clk);
    #1;
    fv0 = fv;
    fm0 = fm;
`ifdef VEC_SEQ_MASK_EN
    cmask = cm;
`endif
    last0  = AW'(last);
    stop0  = stop;
    start0 = 1'b1;
    @(negedge clk);
    chk("busy_before_accept", busy0, 0);
    @(posedge clk);
    #1 start0 = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy0, 1);
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 2000 && !done0; i++) @(negedge clk);
    chk("done0_reached", done0, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = RW'(i * 53 + 7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_err_cnt", err0, 0);
    chk("rst_fail_addr", faddr0, 0);
    chk("rst_fail_xor", fxor0, 0);
    chk("rst_vec", if0.vec, 0);
    chk("rst_rom_addr", if0.rom_addr, 0);
    chk("rst_phase", if0.phase, 0);
    chk("rst_dut_ce", if0.dut_ce, 0);
    chk("rst_state", dut0.state_q, IDLE);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean identity run over the full depth.
    run0(15, 1'b0, 16'h0000, 12'h020, '1);
    wait_done0();

    // Faults at vec 3 and 9 without stop; a stray start mid-run must be ignored.
    run0(15, 1'b0, 16'h0208, 12'h020, '1);
    repeat (10) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0();
    // Held across the DONE->IDLE edge: a start in DONE is ignored.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_sticky", done0, 1);
    chk("no_restart_busy", busy0, 0);
    chk("no_restart_state", dut0.state_q, IDLE);
    chk("err_cnt_held", err0, 2);

    // Same faults, halting at the first one.
    run0(15, 1'b1, 16'h0208, 12'h020, '1);
    wait_done0();

    // Saturating counter on the CW=2, SETTLE=2 unit with an always-failing DUT.
    fm1 = 12'h001;
    exp1_q.push_back(model(7, 1'b0, 16'hFFFF, 12'h001, 2, 2));
    @(posedge clk);
    #1 last1 = 4'd7;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int i = 0; i < 2000 && !done1; i++) @(negedge clk);
    chk("done1_reached", done1, 1);

    // Reset in the APPLY cycle of vec 5, after a fault has already been counted.
    run0(15, 1'b0, 16'h0008, 12'h020, '1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (if0.vec == 4'd5 && if0.phase && !if0.dut_ce) break;
    end
    chk("apply5_vec", if0.vec, 5);
    chk("pre_rst_err_cnt", err0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_vec", if0.vec, 0);
    chk("midrst_err_cnt", err0, 0);
    chk("midrst_fail_xor", fxor0, 0);
    chk("midrst_dut_ce", if0.dut_ce, 0);
    chk("midrst_state", dut0.state_q, IDLE);
    exp0_q.delete();
    vq0.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    run0(15, 1'b0, 16'h0000, 12'h020, '1);
    wait_done0();

    // Bit-8 fault at vec 6, with and without a mask covering it.
`ifdef VEC_SEQ_MASK_EN
    run0(15, 1'b0, 16'h0040, 12'h100, 12'h00F);
    wait_done0();
    run0(15, 1'b0, 16'h0040, 12'h100, 12'h1FF);
    wait_done0();
`else
    run0(15, 1'b0, 16'h0040, 12'h100, '1);
    wait_done0();
`endif

    // Single-vector run with a failing vector 0.
    run0(0, 1'b0, 16'h0001, 12'h800, '1);
    wait_done0();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp0_q.size() + exp1_q.size() + vq0.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/vec_seq.md
# vec_seq

Parametrised, synthesizable vector sequencer and self-checker for bit-slice ALU cores such as the am2901. It fetches per-vector reference words from a synchronous ROM and drives a two-phase stimulus sequence into the device under test (DUT): a preload cycle, then an operate cycle. After a programmable settle time it compares the DUT result against the reference, and it keeps an error count plus first-failure capture. It sits between the vector ROM and the DUT on board-level test builds, so the simulation self-check can run unchanged in hardware.

## Interface
Parameters:
- AW, 12, vector address width; depth is 2^AW.
- RW, 12, reference/result word width.
- CW, 16, error counter width.
- SETTLE, 1, cycles between operate-phase entry and result sampling; legal range is 1 or more.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from vector 0. Ignored while busy.
- stop_on_fail  in  1  sampled at start; when 1, the run halts at the first mismatch.
- vec_last  in  AW  last vector index, inclusive. Sampled at start.
- rom_addr  out  AW  ROM address; equals vec.
- rom_ref  in  RW  ROM data; valid one cycle after rom_addr changes.
- vec  out  AW  current vector index; the DUT stimulus mapping is external.
- phase  out  1  0 = preload phase, 1 = operate phase.
- dut_ce  out  1  one-cycle clock-enable pulse to the DUT register stage.
- dut_res  in  RW  combinational DUT result.
- busy  out  1  high from the cycle after start until the cycle done rises.
- done  out  1  sticky; set at the end of a run and cleared by start.
- fail  out  1  sticky; set on any mismatch and cleared by start.
- err_cnt  out  CW  saturating mismatch count.
- fail_addr  out  AW  vector index of the first mismatch.
- fail_xor  out  RW  dut_res ^ rom_ref at the first mismatch, masked when VEC_SEQ_MASK_EN is defined.

## Operation
State machine:
- IDLE to FETCH on start.
- FETCH lasts 1 cycle. rom_addr is set to vec, and rom_ref becomes valid next cycle.
- PREP lasts 1 cycle. phase is 0 and dut_ce is high.
- APPLY lasts SETTLE cycles. phase is 1 and dut_ce is low.
- CHECK lasts 1 cycle. phase is 1, the compare is registered, and dut_ce is high to commit the operate step.
- From CHECK:
  - on a mismatch with stop_on_fail latched, go to DONE;
  - otherwise, if vec == vec_last, go to DONE;
  - otherwise increment vec and go to FETCH.
- DONE lasts 1 cycle. done is set, busy clears, then the machine returns to IDLE.

Compare and capture:
- mismatch = |(dut_res ^ rom_ref), evaluated in CHECK.
- On a mismatch:
  - err_cnt increments, saturating at 2^CW-1;
  - fail sets;
  - fail_addr and fail_xor load only if fail was previously 0.

Other rules:
- start clears err_cnt, fail, done, fail_addr and fail_xor, loads vec to 0, and latches vec_last and stop_on_fail.
- vec_last = 0 runs exactly one vector.
- vec_last = 2^AW-1 runs the full depth. vec does not wrap, because termination is detected before the increment.

## Timing
- Reset values: vec=0, rom_addr=0, phase=0, dut_ce=0, busy=0, done=0, fail=0, err_cnt=0, fail_addr=0, fail_xor=0. The state is IDLE.
- Cycles per vector: SETTLE+3 (FETCH + PREP + SETTLE x APPLY + CHECK).
- A run of N vectors with no stop takes N*(SETTLE+3) busy cycles. done rises 1 cycle after the last CHECK.
- busy rises the cycle after start.
- start asserted on the same cycle as DONE is ignored. start is accepted from IDLE only.
- rst asserted mid-run: all outputs return to their reset values on the next edge. No dut_ce pulse occurs in that cycle.
- Simultaneous mismatch and vec == vec_last: the error is counted and captured, then the machine enters DONE.

## Configuration
- VEC_SEQ_MASK_EN defined:
  - adds port cmp_mask  in  RW;
  - mismatch = |((dut_res ^ rom_ref) & cmp_mask);
  - fail_xor stores the masked xor;
  - cmp_mask is sampled continuously, not latched.
- Undefined: the port is absent and all RW bits are compared.

## Structure
- Package vec_seq_pkg holds:
  - the state enum (IDLE, FETCH, PREP, APPLY, CHECK, DONE);
  - default parameter constants: AW=12, RW=12, CW=16, SETTLE=1.
- Sub-module vec_seq_cmp holds the masked compare, the saturating err_cnt and the first-fail capture registers.
- The sequencer FSM and the settle counter live in vec_seq.

## Test plan
- Use an identity DUT model (dut_res = rom_ref), AW=4, vec_last=15, SETTLE=1 -> busy for 64 cycles, done=1, fail=0, err_cnt=0, 32 dut_ce pulses.
- Invert dut_res bit 5 at vec 3 and vec 9, stop_on_fail=0, vec_last=15 -> err_cnt=2, fail_addr=3, fail_xor=0x020, done after the full 64 cycles.
- Same faults with stop_on_fail=1 -> done after vec 3, i.e. 16 busy cycles, err_cnt=1, vec=3.
- Use CW=2 with an always-mismatching DUT, vec_last=7 -> err_cnt saturates at 3 and fail_addr=0.
- Assert rst during APPLY of vec 5 -> next cycle busy=0, vec=0, err_cnt=0, dut_ce=0, state IDLE. A following start runs cleanly.
- With VEC_SEQ_MASK_EN defined and cmp_mask=0x00F, a fault on bit 8 -> err_cnt=0. With cmp_mask=0x1FF, the same fault -> err_cnt=1 and fail_xor=0x100.
